// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: byte-bus UART with RX/TX FIFOs, programmable divisor, parity and stop bits
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   rx_sig / tx_sig     serial input (asynchronous) and output, both idle high
//   addr, wdata         register address and write data, qualified by addr_strobe
//   data                registered read data, holds until the next read
//   irq                 registered level interrupt
module uart_fifo_ctrl #(
  parameter int ClockFreqHz = 10000000,
  parameter int BaudRate = 115200,
  parameter int DataBitsSize = 8,
  parameter int ParityMode = 0,
  parameter int StopBitsSize = 1,
  parameter int RxDepth = 16,
  parameter int TxDepth = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_sig,
  output logic       tx_sig,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] data,
  input  logic       addr_strobe,
  output logic       irq
);
  localparam int D = DataBitsSize;
  localparam int RAW = $clog2(RxDepth);
  localparam int TAW = $clog2(TxDepth);
  localparam logic [15:0] DivInit = 16'(ClockFreqHz / BaudRate - 1);
  localparam logic [RAW:0] RxInc = 1;
  localparam logic [TAW:0] TxInc = 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t tx_state, tx_state_n, rx_state, rx_state_n;
  logic [D-1:0] tx_mem [TxDepth];
  logic [D-1:0] rx_mem [RxDepth];
  logic [TAW:0] tx_wp, tx_rp;
  logic [RAW:0] rx_wp, rx_rp, rx_count;
  logic [15:0] divisor, tx_div, tx_cnt, rx_div, rx_cnt;
  logic [D-1:0] tx_shift, rx_shift, tx_head;
  logic [2:0] tx_bits, rx_bits;
  logic [7:0] status, rd_val;
  logic tx_par, tx_stop2, rx_par_bad, rx_push, rx_s1, rx_s2, rx_prev;
  logic rx_ie, tx_ie, rx_ovf, frame_err, parity_err, clr;
  logic tx_load, tx_tick, tx_push, rx_tick, rx_fall, rx_stop_tick, rx_pop, rx_wr, rd_en;
  logic rx_nonempty, rx_full, tx_empty, tx_full, tx_busy;
  assign rx_count = rx_wp - rx_rp;
  assign rx_nonempty = rx_wp != rx_rp;
  assign rx_full = rx_wp[RAW] != rx_rp[RAW] && rx_wp[RAW-1:0] == rx_rp[RAW-1:0];
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full = tx_wp[TAW] != tx_rp[TAW] && tx_wp[TAW-1:0] == tx_rp[TAW-1:0];
  assign tx_busy = tx_state != S_IDLE;
  assign tx_head = tx_mem[tx_rp[TAW-1:0]];
  assign status = {tx_busy, parity_err, frame_err, rx_ovf, tx_full, tx_empty, rx_full, rx_nonempty};
  assign clr = addr_strobe && addr == 4'h2 && wdata[2];
  assign rx_pop = addr_strobe && addr == 4'h1 && rx_nonempty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign rx_wr = rx_push && (!rx_full || rx_pop);
  assign tx_push = addr_strobe && addr == 4'h3 && (!tx_full || tx_load);
  assign rd_en = addr_strobe && (addr == 4'h0 || addr == 4'h1 || addr == 4'h4 || addr == 4'h7);
  assign tx_tick = tx_cnt == '0;
  assign rx_tick = rx_cnt == '0;
  assign rx_fall = rx_prev && !rx_s2;
  assign rx_stop_tick = rx_state == S_STOP && rx_tick;
  assign tx_sig = tx_state == S_START ? 1'b0 : tx_state == S_DATA ? tx_shift[0] : tx_state == S_PAR ? tx_par : 1'b1;
  always_comb
    rd_val = addr == 4'h0 ? status :
             addr == 4'h1 ? (rx_nonempty ? 8'(rx_mem[rx_rp[RAW-1:0]]) : 8'h00) :
             addr == 4'h4 ? 8'(rx_count) : {6'b0, tx_ie, rx_ie};
  always_comb begin
    tx_state_n = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      S_IDLE: if (!tx_empty) begin
        tx_state_n = S_START;
        tx_load = 1'b1;
      end
      S_START: if (tx_tick) tx_state_n = S_DATA;
      S_DATA: if (tx_tick && tx_bits == 3'(D - 1)) tx_state_n = ParityMode != 0 ? S_PAR : S_STOP;
      S_PAR: if (tx_tick) tx_state_n = S_STOP;
      S_STOP: if (tx_tick && (StopBitsSize == 1 || tx_stop2)) begin
        // Chain straight into the next start bit when more data is queued.
        tx_state_n = tx_empty ? S_IDLE : S_START;
        tx_load = !tx_empty;
      end
      default: tx_state_n = S_IDLE;
    endcase
  end
  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      S_IDLE: if (rx_fall) rx_state_n = S_START;
      S_START: if (rx_tick) rx_state_n = rx_s2 ? S_IDLE : S_DATA;
      S_DATA: if (rx_tick && rx_bits == 3'(D - 1)) rx_state_n = ParityMode != 0 ? S_PAR : S_STOP;
      S_PAR: if (rx_tick) rx_state_n = S_STOP;
      S_STOP: if (rx_tick) rx_state_n = S_IDLE;
      default: rx_state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state <= S_IDLE;
      rx_state <= S_IDLE;
    end else begin
      tx_state <= tx_state_n;
      rx_state <= rx_state_n;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_shift <= '0;
      tx_par <= 1'b0;
      tx_div <= '0;
      tx_cnt <= '0;
      tx_bits <= '0;
      tx_stop2 <= 1'b0;
    end else if (tx_load) begin
      tx_shift <= tx_head;
      tx_par <= (^tx_head) ^ (ParityMode == 2);
      tx_div <= divisor;
      tx_cnt <= divisor;
      tx_bits <= '0;
      tx_stop2 <= 1'b0;
    end else if (tx_tick) begin
      tx_cnt <= tx_div;
      if (tx_state == S_DATA) begin
        tx_shift <= tx_shift >> 1;
        tx_bits <= tx_bits + 3'd1;
      end
      if (tx_state == S_STOP) tx_stop2 <= 1'b1;
    end else tx_cnt <= tx_cnt - 16'd1;
  // Edge detection on the synchronized line also re-arms only after it returns high.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {rx_prev, rx_s2, rx_s1} <= 3'b111;
      rx_shift <= '0;
      rx_div <= '0;
      rx_cnt <= '0;
      rx_bits <= '0;
      rx_par_bad <= 1'b0;
      rx_push <= 1'b0;
    end else begin
      {rx_prev, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx_sig};
      rx_push <= rx_stop_tick && rx_s2 && !rx_par_bad;
      if (rx_state == S_IDLE && rx_fall) begin
        rx_div <= divisor;
        rx_cnt <= divisor >> 1;
        rx_bits <= '0;
        rx_par_bad <= 1'b0;
      end else if (rx_tick) begin
        rx_cnt <= rx_div;
        if (rx_state == S_DATA) begin
          rx_shift <= {rx_s2, rx_shift[D-1:1]};
          rx_bits <= rx_bits + 3'd1;
        end
        if (rx_state == S_PAR) rx_par_bad <= rx_s2 ^ (^rx_shift) ^ (ParityMode == 2);
      end else rx_cnt <= rx_cnt - 16'd1;
    end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= wdata[D-1:0];
    if (rx_wr) rx_mem[rx_wp[RAW-1:0]] <= rx_shift;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      irq <= 1'b0;
      divisor <= DivInit;
      {tx_ie, rx_ie} <= 2'b00;
      {rx_ovf, frame_err, parity_err} <= 3'b000;
      rx_wp <= '0;
      rx_rp <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (addr_strobe && addr == 4'h2) {tx_ie, rx_ie} <= wdata[1:0];
      if (addr_strobe && addr == 4'h5) divisor[7:0] <= wdata;
      if (addr_strobe && addr == 4'h6) divisor[15:8] <= wdata;
      if (rd_en) data <= rd_val;
      rx_ovf <= (rx_ovf && !clr) || (rx_push && rx_full && !rx_pop);
      frame_err <= (frame_err && !clr) || (rx_stop_tick && !rx_s2);
      parity_err <= (parity_err && !clr) || (rx_stop_tick && rx_s2 && rx_par_bad);
      if (rx_wr) rx_wp <= rx_wp + RxInc;
      if (rx_pop) rx_rp <= rx_rp + RxInc;
      if (tx_push) tx_wp <= tx_wp + TxInc;
      if (tx_load) tx_rp <= tx_rp + TxInc;
      irq <= (rx_ie && (rx_nonempty || rx_ovf || frame_err || parity_err)) || (tx_ie && tx_empty && !tx_busy);
    end
endmodule
